// File: rtl/host_if_pkg.sv
// rtl/host_if_pkg.sv - shared opcodes, control bit index and state types for the host register bus
package host_if_pkg;

  // Bus state codes driven on state_o
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] SETEP     = 4'd1;
  localparam logic [3:0] SETREG    = 4'd2;
  localparam logic [3:0] SETRVAL   = 4'd3;
  localparam logic [3:0] RDDATA    = 4'd4;
  localparam logic [3:0] RESETRVAL = 4'd5;
  localparam logic [3:0] WRDATA    = 4'd7;

  // ctl bit carrying the read/write strobe
  localparam int CTL_RDWR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_STROBE,
    S_HOLD,
    S_WAITRDY,
    S_GAP,
    S_DONE
  } mst_state_e;

  // Which phase of the command is on the bus; the last one is SETRVAL or RDDATA
  typedef enum logic [1:0] {
    PH_EP,
    PH_REG,
    PH_VAL
  } mst_phase_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] phase_op(input mst_phase_e ph, input logic wr);
    case (ph)
      PH_EP:   return SETEP;
      PH_REG:  return SETREG;
      default: return wr ? SETRVAL : RDDATA;
    endcase
  endfunction

endpackage

// File: rtl/host_if_phase_timer.sv
// rtl/host_if_phase_timer.sv - reloadable down-counter timing each bus state
module host_if_phase_timer #(
  parameter int W = 11
) (
  input  logic         if_clock,
  input  logic         resetb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // A reload wins; otherwise count down and rest at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // Counter register
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/host_interface_master.sv
// rtl/host_interface_master.sv - initiator for the state-coded host register bus
module host_interface_master
  import host_if_pkg::*;
#(
  parameter int SETTLE_CYC  = 2,
  parameter int HOLD_CYC    = 2,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 1024,
  parameter int EP_CACHE    = 1
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_ep,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [3:0]  state_o,
  output logic [2:0]  ctl_o,
  input  logic        rdy_i,
  output logic [15:0] data_o,
  output logic        data_oe,
  input  logic [15:0] data_i
);

  localparam int MAX_CYC = max_of(max_of(SETTLE_CYC, HOLD_CYC), max_of(GAP_CYC, TIMEOUT_CYC));
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Timer reload values: a state lasting N cycles expires on its Nth cycle
  localparam logic [CW-1:0] SETTLE_LD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYC - 1);

  mst_state_e state_d, state_q;
  mst_phase_e phase_d, phase_q;

  logic        write_d, write_q;
  logic [15:0] ep_d, ep_q;
  logic [15:0] addr_d, addr_q;
  logic [15:0] wdata_d, wdata_q;
  logic [15:0] rd_d, rd_q;
  logic        to_d, to_q;
  logic [15:0] cache_ep_d, cache_ep_q;
  logic        cache_vld_d, cache_vld_q;

  logic        cmd_ready_d, cmd_ready_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic [15:0] rsp_rdata_d, rsp_rdata_q;
  logic        rsp_timeout_d, rsp_timeout_q;
  logic        busy_d, busy_q;
  logic [3:0]  bus_state_d, bus_state_q;
  logic [2:0]  ctl_d, ctl_q;
  logic [15:0] data_o_d, data_o_q;
  logic        data_oe_d, data_oe_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_expired;
  logic [3:0]    cur_op;
  logic [3:0]    next_op;
  logic          next_drive;
  logic [15:0]   next_pval;

  host_if_phase_timer #(
    .W (CW)
  ) u_timer (
    .if_clock (if_clock),
    .resetb   (resetb),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  assign cur_op = phase_op(phase_q, write_q);

  // Phase sequencing, command capture, read-data capture and endpoint cache
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    write_d       = write_q;
    ep_d          = ep_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rd_d          = rd_q;
    to_d          = to_q;
    cache_ep_d    = cache_ep_q;
    cache_vld_d   = cache_vld_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d  = cmd_write;
          ep_d     = cmd_ep;
          addr_d   = cmd_addr;
          wdata_d  = cmd_wdata;
          rd_d     = '0;
          to_d     = 1'b0;
          phase_d  = ((EP_CACHE != 0) && cache_vld_q && (cmd_ep == cache_ep_q)) ? PH_REG : PH_EP;
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        if (tmr_expired) begin
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        tmr_load = 1'b1;
        if (cur_op == RDDATA) begin
          state_d = S_WAITRDY;
          tmr_val = TIMEOUT_LD;
        end else begin
          state_d = S_HOLD;
          tmr_val = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (tmr_expired) begin
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      S_WAITRDY: begin
        // rdy_i is checked first so it wins over a same-cycle timeout
        if (rdy_i) begin
          rd_d     = data_i;
          to_d     = 1'b0;
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end else if (tmr_expired) begin
          rd_d     = '0;
          to_d     = 1'b1;
          state_d  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          if (phase_q == PH_VAL) begin
            state_d       = S_DONE;
            rsp_rdata_d   = rd_q;
            rsp_timeout_d = to_q;
            if (to_q) begin
              cache_vld_d = 1'b0;
            end else begin
              cache_ep_d  = ep_q;
              cache_vld_d = 1'b1;
            end
          end else begin
            phase_d  = (phase_q == PH_EP) ? PH_REG : PH_VAL;
            state_d  = S_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decoded from the next state so they register in step with it
  always_comb begin
    next_op    = phase_op(phase_d, write_d);
    next_drive = (state_d inside {S_SETTLE, S_STROBE, S_HOLD}) && (next_op != RDDATA);
    case (phase_d)
      PH_EP:   next_pval = ep_d;
      PH_REG:  next_pval = addr_d;
      default: next_pval = wdata_d;
    endcase
    bus_state_d     = (state_d inside {S_SETTLE, S_STROBE, S_HOLD, S_WAITRDY}) ? next_op : IDLE;
    ctl_d           = '0;
    ctl_d[CTL_RDWR] = (state_d == S_STROBE);
    data_oe_d       = next_drive;
    data_o_d        = next_drive ? next_pval : '0;
    cmd_ready_d     = (state_d == S_IDLE);
    busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
    rsp_valid_d     = (state_d == S_DONE);
  end

  // All FSM and output registers; reset drops any command in flight and the cache
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_EP;
      write_q       <= 1'b0;
      ep_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      to_q          <= 1'b0;
      cache_ep_q    <= '0;
      cache_vld_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      bus_state_q   <= IDLE;
      ctl_q         <= '0;
      data_o_q      <= '0;
      data_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      write_q       <= write_d;
      ep_q          <= ep_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rd_q          <= rd_d;
      to_q          <= to_d;
      cache_ep_q    <= cache_ep_d;
      cache_vld_q   <= cache_vld_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
      bus_state_q   <= bus_state_d;
      ctl_q         <= ctl_d;
      data_o_q      <= data_o_d;
      data_oe_q     <= data_oe_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign state_o     = bus_state_q;
  assign ctl_o       = ctl_q;
  assign data_o      = data_o_q;
  assign data_oe     = data_oe_q;

endmodule

// File: tb/tb_host_interface_master.sv
// tb/tb_host_interface_master.sv - directed self-checking bench for host_interface_master
module tb_host_interface_master;

  logic        if_clock = 1'b0;
  logic        resetb   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_ep = '0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        busy;
  logic [3:0]  state_o;
  logic [2:0]  ctl_o;
  logic        rdy_i = 1'b0;
  logic [15:0] data_o;
  logic        data_oe;
  logic [15:0] data_i = 16'hDEAD;

  host_interface_master #(
    .SETTLE_CYC  (2),
    .HOLD_CYC    (2),
    .GAP_CYC     (1),
    .TIMEOUT_CYC (16),
    .EP_CACHE    (1)
  ) dut (
    .if_clock    (if_clock),
    .resetb      (resetb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_ep      (cmd_ep),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .state_o     (state_o),
    .ctl_o       (ctl_o),
    .rdy_i       (rdy_i),
    .data_o      (data_o),
    .data_oe     (data_oe),
    .data_i      (data_i)
  );

  always #5 if_clock = ~if_clock;

  int checks = 0;
  int errors = 0;

  logic [3:0]  rec_st [0:63];
  logic [2:0]  rec_ct [0:63];
  logic [15:0] rec_d  [0:63];
  logic        rec_oe [0:63];
  logic        rec_bz [0:63];
  logic        rec_rdy[0:63];
  logic [15:0] rec_rr [0:63];
  int          rv_cyc;
  logic        rv_to;
  logic [15:0] rv_rd;

  bit mon_en = 1'b0;
  int mcyc = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int acc_cyc = 0;
  int bad_lat = 0;
  int rsp_bad = 0;
  int strobe_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge if_clock);
      n++;
    end
    check_eq("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Issue one command and log the bus cycle by cycle; index 1 is the first cycle after accept
  task automatic run_cmd(input logic w, input logic [15:0] ep, input logic [15:0] addr,
                         input logic [15:0] wd, input int rdy_dly);
    int strobe_rd = -1;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_ep    = ep;
    cmd_addr  = addr;
    cmd_wdata = wd;
    rv_cyc    = 0;
    for (int c = 1; c < 64 && rv_cyc == 0; c++) begin
      @(negedge if_clock);
      if (c == 1) cmd_valid = 1'b0;
      rec_st[c] = state_o;
      rec_ct[c] = ctl_o;
      rec_d[c]  = data_o;
      rec_oe[c] = data_oe;
      rec_bz[c] = busy;
      rec_rdy[c] = cmd_ready;
      rec_rr[c] = rsp_rdata;
      if (rsp_valid) begin
        rv_cyc = c;
        rv_to  = rsp_timeout;
        rv_rd  = rsp_rdata;
      end
      if (ctl_o[1] && state_o == 4'd4) strobe_rd = c;
      rdy_i  = 1'b0;
      data_i = 16'hDEAD;
      if (strobe_rd > 0 && rdy_dly > 0 && c == strobe_rd + rdy_dly) begin
        rdy_i  = 1'b1;
        data_i = 16'h1234;
      end
    end
    rdy_i  = 1'b0;
    data_i = 16'hDEAD;
  endtask

  // One non-read phase: 2 settle, strobe, 2 hold with data driven, then 1 gap cycle
  task automatic check_phase(input string tag, input int b, input logic [3:0] op, input logic [15:0] val);
    int bad = 0;
    logic [3:0] es;
    logic [2:0] ec;
    logic       eo;
    for (int k = 0; k < 6; k++) begin
      es = (k == 5) ? 4'd0 : op;
      ec = (k == 2) ? 3'b010 : 3'b000;
      eo = (k < 5);
      if (rec_st[b+k] !== es || rec_ct[b+k] !== ec || rec_oe[b+k] !== eo) bad++;
      if (eo && rec_d[b+k] !== val) bad++;
    end
    check_eq({tag, "_seq_bad"}, 32'(bad), 32'd0);
    check_eq({tag, "_strobe_data"}, 32'(rec_d[b+2]), 32'(val));
  endtask

  // Protocol monitor, sampled just after the falling edge
  initial begin
    forever begin
      @(negedge if_clock);
      #1;
      mcyc++;
      if (ctl_o[1] && state_o == 4'd0) strobe_bad++;
      if (ctl_o[0] || ctl_o[2]) strobe_bad++;
      if (mon_en) begin
        if (rsp_valid) begin
          rsp_cnt++;
          if (mcyc - acc_cyc != 13) bad_lat++;
          if (rsp_timeout || rsp_rdata != 16'h0) rsp_bad++;
        end
        if (cmd_valid && cmd_ready) begin
          acc_cnt++;
          acc_cyc = mcyc;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;

    // Reset values
    repeat (2) @(negedge if_clock);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state_o", 32'(state_o), 32'd0);
    check_eq("rst_ctl_o", 32'(ctl_o), 32'd0);
    check_eq("rst_data_o", 32'(data_o), 32'd0);
    check_eq("rst_data_oe", 32'(data_oe), 32'd0);
    resetb = 1'b1;
    @(negedge if_clock);
    check_eq("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

    // W1: cold cache, full three-phase write
    run_cmd(1'b1, 16'h0005, 16'h0012, 16'hBEEF, 0);
    check_eq("w1_rv_cycle", 32'(rv_cyc), 32'd19);
    check_eq("w1_busy", 32'(rec_bz[1]), 32'd1);
    check_eq("w1_cmd_ready_low", 32'(rec_rdy[1]), 32'd0);
    check_phase("w1_ep", 1, 4'd1, 16'h0005);
    check_phase("w1_reg", 7, 4'd2, 16'h0012);
    check_phase("w1_val", 13, 4'd3, 16'hBEEF);
    check_eq("w1_timeout", 32'(rv_to), 32'd0);
    check_eq("w1_rdata", 32'(rv_rd), 32'd0);

    // W2: same endpoint, SETEP skipped
    run_cmd(1'b1, 16'h0005, 16'h0013, 16'h1111, 0);
    check_eq("w2_rv_cycle", 32'(rv_cyc), 32'd13);
    check_phase("w2_reg", 1, 4'd2, 16'h0013);
    check_phase("w2_val", 7, 4'd3, 16'h1111);

    // W3: new endpoint, SETEP returns
    run_cmd(1'b1, 16'h0006, 16'h0020, 16'h2222, 0);
    check_eq("w3_rv_cycle", 32'(rv_cyc), 32'd19);
    check_phase("w3_ep", 1, 4'd1, 16'h0006);

    // R1: cached endpoint, rdy 4 cycles after the RDDATA strobe at cycle 9
    run_cmd(1'b0, 16'h0006, 16'h0030, 16'h0000, 4);
    check_phase("r1_reg", 1, 4'd2, 16'h0030);
    check_eq("r1_rd_state", 32'(rec_st[7]), 32'd4);
    check_eq("r1_rd_strobe", 32'(rec_ct[9]), 32'd2);
    bad = 0;
    for (int c = 7; c <= 14; c++) if (rec_oe[c] !== 1'b0) bad++;
    check_eq("r1_oe_during_rddata", 32'(bad), 32'd0);
    check_eq("r1_rv_cycle", 32'(rv_cyc), 32'd15);
    check_eq("r1_rdata", 32'(rv_rd), 32'h1234);
    check_eq("r1_timeout", 32'(rv_to), 32'd0);
    repeat (3) @(negedge if_clock);
    check_eq("r1_rdata_held", 32'(rsp_rdata), 32'h1234);

    // R2: rdy never comes, timeout after 16 wait cycles
    run_cmd(1'b0, 16'h0006, 16'h0040, 16'h0000, 0);
    check_eq("r2_rv_cycle", 32'(rv_cyc), 32'd27);
    check_eq("r2_timeout", 32'(rv_to), 32'd1);
    check_eq("r2_rdata", 32'(rv_rd), 32'd0);
    check_eq("r2_rdata_held_before_done", 32'(rec_rr[26]), 32'h1234);

    // W4: cache invalidated by the timeout
    run_cmd(1'b1, 16'h0006, 16'h0041, 16'h5555, 0);
    check_eq("w4_rv_cycle", 32'(rv_cyc), 32'd19);
    check_phase("w4_ep", 1, 4'd1, 16'h0006);

    // Reset in the middle of a cached write's SETREG strobe
    wait_ready();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_ep    = 16'h0006;
    cmd_addr  = 16'h0050;
    cmd_wdata = 16'h3333;
    @(negedge if_clock);
    cmd_valid = 1'b0;
    check_eq("rm_state_setreg", 32'(state_o), 32'd2);
    repeat (2) @(negedge if_clock);
    check_eq("rm_strobe", 32'(ctl_o), 32'd2);
    check_eq("rm_oe", 32'(data_oe), 32'd1);
    resetb = 1'b0;
    #1;
    check_eq("rm_state_o", 32'(state_o), 32'd0);
    check_eq("rm_ctl_o", 32'(ctl_o), 32'd0);
    check_eq("rm_data_o", 32'(data_o), 32'd0);
    check_eq("rm_data_oe", 32'(data_oe), 32'd0);
    check_eq("rm_busy", 32'(busy), 32'd0);
    check_eq("rm_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge if_clock);
    resetb = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge if_clock);
      if (rsp_valid || state_o != 4'd0) bad++;
    end
    check_eq("rm_dropped", 32'(bad), 32'd0);

    // W5: cache invalidated by reset
    run_cmd(1'b1, 16'h0006, 16'h0051, 16'h6666, 0);
    check_eq("w5_rv_cycle", 32'(rv_cyc), 32'd19);
    check_phase("w5_ep", 1, 4'd1, 16'h0006);

    // Back-to-back: cmd_valid held high, rdy_i toggling with no read in flight
    @(negedge if_clock);
    mon_en    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_ep    = 16'h0006;
    cmd_addr  = 16'h0060;
    cmd_wdata = 16'h4444;
    for (int i = 0; i < 150; i++) begin
      @(negedge if_clock);
      rdy_i  = 1'($urandom_range(0, 1));
      data_i = 16'($urandom);
    end
    cmd_valid = 1'b0;
    rdy_i     = 1'b0;
    repeat (30) @(negedge if_clock);
    mon_en = 1'b0;
    @(negedge if_clock);
    check_eq("b2b_acc_eq_rsp", 32'(acc_cnt), 32'(rsp_cnt));
    check_eq("b2b_acc_min", 32'(acc_cnt >= 10), 32'd1);
    check_eq("b2b_latency_bad", 32'(bad_lat), 32'd0);
    check_eq("b2b_rsp_bad", 32'(rsp_bad), 32'd0);
    check_eq("strobe_while_idle", 32'(strobe_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_interface_master.md
Name: host_interface_master

Overview:
- Initiator end of the 16-bit state-coded host register bus: the side that drives state code, ctl and write data, and waits on rdy.
- Converts single register-write and register-read commands into the SETEP / SETREG / SETRVAL / RDDATA phase sequence with the setup and hold spacing the responder requires.
- Used in FPGA-to-FPGA bridging and as the bus driver in system benches. Shares if_clock with the responder.

Parameters:
- SETTLE_CYC, 2: cycles the state code is held stable before the strobe; legal minimum is 2.
- HOLD_CYC, 2: cycles the state code and data are held after the strobe; legal minimum is 2.
- GAP_CYC, 1: IDLE (0) cycles driven between phases; legal minimum is 1.
- TIMEOUT_CYC, 1024: maximum cycles from the RDDATA strobe to rdy.
- EP_CACHE, 1: 1 skips the SETEP phase when the endpoint is unchanged since the last completed command.

Ports:
- if_clock  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_ep  in  16  endpoint address
- cmd_addr  in  16  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  read data; 0 for writes and on timeout
- rsp_timeout  out  1  qualified by rsp_valid
- busy  out  1  high from command accept until rsp_valid
- state_o  out  4  bus state code
- ctl_o  out  3  bus control; bit1 = rdwr strobe, bits 0 and 2 always 0
- rdy_i  in  1  responder read-data-ready
- data_o  out  16  bus write data
- data_oe  out  1  bus output enable, to the top-level tristate
- data_i  in  16  bus read data

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, busy=0, state_o=0, ctl_o=0, data_o=0, data_oe=0. Endpoint cache is invalid. cmd_ready rises on the first clock after reset release.
- Opcodes: IDLE=0, SETEP=1, SETREG=2, SETRVAL=3, RDDATA=4.
- Command capture: cmd_ep, cmd_addr, cmd_wdata and cmd_write are registered on accept. cmd_ready is high only in S_IDLE.
- Phase list:
  - Write: [SETEP], SETREG, SETRVAL.
  - Read: [SETEP], SETREG, RDDATA.
  - SETEP is omitted only when EP_CACHE=1, the cache is valid, and cmd_ep equals the cached endpoint.
- FSM states:
  - S_IDLE.
  - S_SETTLE: state_o=op, ctl_o=0, for SETTLE_CYC cycles.
  - S_STROBE: ctl_o[1]=1 for exactly 1 cycle.
  - S_HOLD: state_o=op, ctl_o=0, for HOLD_CYC cycles (write phases only).
  - S_WAITRDY: RDDATA only.
  - S_GAP: state_o=0 for GAP_CYC cycles.
  - S_DONE: 1 cycle.
- Transitions: S_GAP goes to S_SETTLE of the next phase, or to S_DONE after the last phase. S_DONE goes to S_IDLE.
- Write phases: data_o is the phase value (ep, addr or wdata) and data_oe=1 throughout S_SETTLE, S_STROBE and S_HOLD. data_oe=0 in all other states.
- RDDATA phase: data_oe=0 throughout. After S_STROBE, enter S_WAITRDY and sample rdy_i every cycle.
  - First cycle rdy_i=1: capture data_i into rsp_rdata, then go to S_GAP.
  - Timeout: if rdy_i is not seen within TIMEOUT_CYC cycles, set rsp_timeout=1 and rsp_rdata=0, then go to S_GAP.
  - The timeout counter starts at 0 on entry to S_WAITRDY.
  - If rdy_i=1 and the timeout occur on the same cycle, rdy wins.
- S_DONE: rsp_valid=1. rsp_rdata and rsp_timeout are held until the next S_DONE.
  - Cache is updated to the current ep, cache valid=1, on non-timeout completion.
  - On timeout, the cache is invalidated.
- Latency with defaults: 6 cycles per non-read phase (2+1+2+1).
  - Accept at edge T: state_o=SETEP during cycles T+1..T+2, strobe at T+3.
  - Write with SETEP: rsp_valid in cycle T+19.
  - Write with cached ep: rsp_valid in cycle T+13.
- rdy_i is ignored outside S_WAITRDY. A rdy_i glitch in any other state has no effect.
- cmd_valid while busy: ignored; the command is not accepted.
- Reset assertion mid-command: all outputs return to reset values asynchronously, the command is dropped with no rsp_valid, and the cache is invalidated.
- Counters: one shared phase counter of width clog2(max(SETTLE_CYC, HOLD_CYC, GAP_CYC, TIMEOUT_CYC)+1). It wraps never; it reloads on every state entry.

Decomposition:
- Shared package host_if_pkg holds the opcode constants (IDLE, SETEP, SETREG, SETRVAL, RDDATA, RESETRVAL=5, WRDATA=7) and the CTL_RDWR bit index (1). The responder and this block both use it.
- One sub-module: host_if_phase_timer (load/count/expire) as the shared down-counter. Everything else lives in a single FSM.

Test Plan:
- Write ep=0x0005, addr=0x0012, data=0xBEEF after reset -> state_o sequence 1,0,2,0,3,0 with strobes at T+3, T+9, T+15; data_o matches each phase while data_oe=1; rsp_valid at T+19 with rsp_timeout=0.
- Repeat write with ep=0x0005, addr=0x0013 -> no SETEP phase; rsp_valid at T+13. Third command with ep=0x0006 -> SETEP reappears.
- Read with the responder model asserting rdy_i 4 cycles after the strobe and data_i=0x1234 -> data_oe=0 during RDDATA; rsp_rdata=0x1234, rsp_timeout=0.
- Read with rdy_i never asserted and TIMEOUT_CYC=16 -> rsp_valid exactly 16+GAP_CYC+1 cycles after the strobe, rsp_timeout=1, rsp_rdata=0; next command reissues SETEP.
- resetb pulsed low during SETREG of a write -> all outputs zero immediately; no rsp_valid; next write emits SETEP.
- Back-to-back cmd_valid held high with rdy_i toggling randomly outside S_WAITRDY -> exactly one accept per rsp_valid; never ctl_o[1]=1 while state_o=0; no rsp change from stray rdy_i.
